// File: rtl/ffapuf_pkg.sv
// Shared definitions for the FF-APUF evaluation sequencer: FSM encoding,
// fixed dwell constants and the Galois LFSR tap table.
package ffapuf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_APPLY,
      S_LAUNCH,
      S_WAIT,
      S_SAMPLE,
      S_PRESENT
   } state_t;

   // Slice clear pulse length and synchronizer depth, in clock cycles.
   localparam int CLR_CYC  = 2;
   localparam int SYNC_CYC = 2;

   // Right-shifting Galois tap mask; bit (e-1) set for each polynomial term x^e.
   function automatic logic [63:0] lfsr_taps(input int w);
      case (w)
         8:       return 64'h0000_0000_0000_00B8;
         12:      return 64'h0000_0000_0000_0E08;
         16:      return 64'h0000_0000_0000_B400;  // x^16+x^14+x^13+x^11
         24:      return 64'h0000_0000_00E1_0000;
         32:      return 64'h0000_0000_A300_0000;
         default: return 64'h0000_0000_0000_B400;
      endcase
   endfunction

endpackage

// File: rtl/ffapuf_chal_lfsr.sv
// Challenge LFSR: loads the batch seed (a zero seed is forced to 1 so the
// register never locks up) and takes one Galois step per request.
module ffapuf_chal_lfsr
   import ffapuf_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = 12
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          load,
   input  logic          step,
   input  logic [W-1:0]  seed,
   output logic [CW-1:0] chal
);

   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

   logic [W-1:0] q;

   assign chal = q[CW-1:0];

   // Seed load has priority over stepping.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         q <= '0;
      else if (load)
         q <= (seed == '0) ? W'(1) : seed;
      else if (step)
         q <= (q >> 1) ^ (q[0] ? TAPS : '0);
   end

endmodule

// File: rtl/ffapuf_eval_sequencer.sv
// Batch challenge-response sequencer for a bank of FF-APUF slices.
// Optional feature: define FFAPUF_MAJ_VOTE_EN to evaluate each challenge
// N_VOTE times and report the per-slice majority.
module ffapuf_eval_sequencer
   import ffapuf_pkg::*;
#(
   parameter int N_SLICES = 4,
   parameter int SETTLE   = 4,
   parameter int LFSR_W   = 16,
   parameter int N_VOTE   = 5
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            num_chal,
   input  logic [LFSR_W-1:0]     seed,
   output logic                  puf_clr,
   output logic                  puf_launch,
   output logic [3*N_SLICES-1:0] puf_chal,
   input  logic [N_SLICES-1:0]   puf_resp,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [N_SLICES-1:0]   resp_data,
   output logic [3*N_SLICES-1:0] resp_chal,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = 3*N_SLICES;
   localparam int TW = $clog2(SETTLE+1) + 1;

   if (SETTLE < 1 || LFSR_W < CW || N_VOTE < 3 || (N_VOTE % 2) == 0) begin : g_bad_cfg
      $error("ffapuf_eval_sequencer: illegal parameter combination");
   end

   state_t                state, nxt;
   logic [TW-1:0]         tmr, dwell;
   logic                  last, more, ab;
   logic                  lfsr_load, lfsr_step;
   logic [7:0]            cnt;
   logic [CW-1:0]         lfsr_chal;
   logic [N_SLICES-1:0]   sync1, sync2, word;

   // Abort only means something once a batch is running.
   assign ab = abort & (state != S_IDLE);

   // Outputs decode straight from the state register, so they reset cleanly.
   assign puf_clr    = (state inside {S_APPLY, S_LAUNCH, S_WAIT, S_SAMPLE, S_PRESENT});
   assign puf_launch = (state == S_LAUNCH);
   assign resp_valid = (state == S_PRESENT);
   assign busy       = (state != S_IDLE);

   ffapuf_chal_lfsr #(.W(LFSR_W), .CW(CW)) u_lfsr (
      .clk  (clk),
      .clr  (clr),
      .load (lfsr_load),
      .step (lfsr_step),
      .seed (seed),
      .chal (lfsr_chal)
   );

   // Dwell length of the current state; last marks its final cycle.
   always_comb begin
      dwell = TW'(1);
      case (state)
         S_CLEAR:         dwell = TW'(CLR_CYC);
         S_APPLY, S_WAIT: dwell = TW'(SETTLE);
         S_SAMPLE:        dwell = TW'(SYNC_CYC);
         default:         dwell = TW'(1);
      endcase
   end

   assign last = (tmr == dwell - TW'(1));

   // Next-state and LFSR control; abort overrides everything else.
   always_comb begin
      nxt       = state;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state)
         S_IDLE:    if (start && num_chal != 8'd0) begin
                       nxt       = S_CLEAR;
                       lfsr_load = 1'b1;
                    end
         S_CLEAR:   if (last) nxt = S_APPLY;
         S_APPLY:   if (last) nxt = S_LAUNCH;
         S_LAUNCH:  if (last) nxt = S_WAIT;
         S_WAIT:    if (last) nxt = S_SAMPLE;
         S_SAMPLE:  if (last) nxt = more ? S_CLEAR : S_PRESENT;
         S_PRESENT: if (resp_ready) begin
                       lfsr_step = 1'b1;
                       nxt       = (cnt == 8'd1) ? S_IDLE : S_CLEAR;
                    end
         default:   nxt = S_IDLE;
      endcase
      if (ab) begin
         nxt       = S_IDLE;
         lfsr_step = 1'b0;
      end
   end

   // State register plus a dwell timer that restarts on every state change.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else begin
         state <= nxt;
         if (nxt != state || state == S_IDLE || state == S_PRESENT)
            tmr <= '0;
         else
            tmr <= tmr + TW'(1);
      end
   end

   // Two-flop synchronizer on the asynchronous slice responses.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= puf_resp;
         sync2 <= sync1;
      end
   end

   // Batch counter, done pulse, challenge latch and response capture.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt       <= '0;
         done      <= 1'b0;
         puf_chal  <= '0;
         resp_data <= '0;
         resp_chal <= '0;
      end else begin
         done <= ab | (lfsr_step && cnt == 8'd1);
         if (lfsr_load)
            cnt <= num_chal;
         else if (lfsr_step)
            cnt <= cnt - 8'd1;
         if (state == S_CLEAR)
            puf_chal <= lfsr_chal;
         if (state == S_SAMPLE && last && !more && !ab) begin
            resp_data <= word;
            resp_chal <= puf_chal;
         end
      end
   end

`ifdef FFAPUF_MAJ_VOTE_EN
   localparam int VW  = $clog2(N_VOTE+1);
   localparam int VCW = $clog2(N_VOTE);

   logic [VCW-1:0] vcnt;
   logic           smp_end;

   assign smp_end = (state == S_SAMPLE) && last;
   assign more    = (vcnt != VCW'(N_VOTE-1));

   // Evaluation index within the current challenge; cleared on abort or idle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         vcnt <= '0;
      else if (ab || state == S_IDLE)
         vcnt <= '0;
      else if (smp_end)
         vcnt <= more ? vcnt + VCW'(1) : '0;
   end

   for (genvar g = 0; g < N_SLICES; g++) begin : g_vote
      logic [VW-1:0] ones, tot;

      // tot includes the sample being taken this cycle.
      assign tot     = ones + VW'(sync2[g]);
      assign word[g] = (tot > VW'(N_VOTE/2));

      // Per-slice ones counter; partial counts are dropped on abort.
      always_ff @(posedge clk or negedge clr) begin
         if (!clr)
            ones <= '0;
         else if (ab || state == S_IDLE)
            ones <= '0;
         else if (smp_end)
            ones <= more ? tot : '0;
      end
   end
`else
   assign more = 1'b0;
   assign word = sync2;
`endif

endmodule

// File: tb/tb_ffapuf_eval_sequencer.sv
// Self-checking bench for ffapuf_eval_sequencer (either FFAPUF_MAJ_VOTE_EN build).
module tb_ffapuf_eval_sequencer;

   localparam int NS     = 4;
   localparam int SETTLE = 4;
   localparam int LW     = 16;
   localparam int CW     = 3*NS;
`ifdef FFAPUF_MAJ_VOTE_EN
   localparam int NV = 5;
`else
   localparam int NV = 1;
`endif
   localparam int LAT = NV*(2*SETTLE+5);

   logic          clk, clr, start, abort, resp_ready;
   logic [7:0]    num_chal;
   logic [LW-1:0] seed;
   logic [NS-1:0] puf_resp, resp_data;
   logic [CW-1:0] puf_chal, resp_chal;
   logic          puf_clr, puf_launch, resp_valid, busy, done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [NS-1:0] force_q[$];

   ffapuf_eval_sequencer #(
      .N_SLICES(NS), .SETTLE(SETTLE), .LFSR_W(LW), .N_VOTE(5)
   ) dut (
      .clk(clk), .clr(clr), .start(start), .abort(abort), .num_chal(num_chal),
      .seed(seed), .puf_clr(puf_clr), .puf_launch(puf_launch), .puf_chal(puf_chal),
      .puf_resp(puf_resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_chal(resp_chal), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference LFSR: polynomial x^16+x^14+x^13+x^11 as a right-shift Galois register.
   function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] s);
      int ex[4] = '{16, 14, 13, 11};
      logic [LW-1:0] mask = '0;
      foreach (ex[i]) mask[ex[i]-1] = 1'b1;
      return (s >> 1) ^ (s[0] ? mask : '0);
   endfunction

   // Per-slice majority over every sample taken for one challenge.
   function automatic logic [NS-1:0] majority(input logic [NS-1:0] q[$]);
      logic [NS-1:0] r = '0;
      for (int s = 0; s < NS; s++) begin
         int ones = 0;
         foreach (q[i]) ones += int'(q[i][s]);
         r[s] = (ones > q.size()/2);
      end
      return r;
   endfunction

   // Runs a whole batch, checking every challenge against the model.
   task automatic run_batch(input logic [LW-1:0] sd, input int n, input int stall,
                            input logic [CW-1:0] exp_first, input bit noise);
      logic [LW-1:0] m;
      logic [CW-1:0] echal, hc;
      logic [NS-1:0] hd, r;
      logic [NS-1:0] rlog[$];
      int k, launches, dones;
      bit stable;
      m = (sd == '0) ? LW'(1) : sd;
      seed = sd; num_chal = 8'(n); start = 1'b1; resp_ready = (stall == 0);
      cyc();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int c = 0; c < n; c++) begin
         echal = m[CW-1:0]; launches = 0; dones = 0; k = 0; rlog.delete();
         while (!resp_valid && k < LAT+4) begin
            if (puf_launch) begin
               launches++;
               chk("launch_chal", puf_chal, echal);
               r = (force_q.size() != 0) ? force_q.pop_front() : NS'($urandom);
               puf_resp = r;
               rlog.push_back(r);
            end
            if (done) dones++;
            if (noise) begin
               start = 1'($urandom_range(0, 1)); seed = LW'($urandom); num_chal = 8'($urandom);
            end
            cyc();
            k++;
         end
         start = 1'b0;
         chk("latency", k, LAT);
         if (!resp_valid) return;
         chk("launches", launches, NV);
         chk("no_early_done", dones, 0);
         chk("resp_chal", resp_chal, echal);
         if (c == 0) chk("first_chal", resp_chal, exp_first);
         chk("resp_data", resp_data, majority(rlog));
         if (stall > 0) begin
            hd = resp_data; hc = resp_chal; stable = 1'b1;
            repeat (stall) begin
               cyc();
               if (!resp_valid || resp_data !== hd || resp_chal !== hc) stable = 1'b0;
            end
            chk("stall_stable", stable, 1);
            resp_ready = 1'b1;
         end
         cyc();
         if (stall > 0) resp_ready = 1'b0;
         m = lfsr_next(m);
         if (c == n-1) begin
            chk("done_final", done, 1);
            chk("busy_final", busy, 0);
            chk("valid_final", resp_valid, 0);
            cyc();
            chk("done_single", done, 0);
         end else begin
            chk("done_mid", done, 0);
            chk("busy_mid", busy, 1);
         end
      end
      resp_ready = 1'b0;
   endtask

   typedef struct {
      logic [LW-1:0] sd;
      int            n;
      int            stall;
      logic [CW-1:0] ef;
      bit            noise;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int k, dn, n, st;
      logic [LW-1:0] sd;

      tbl[0] = '{16'hACE1, 1, 0,  12'hCE1, 1'b0};  // basic
      tbl[1] = '{16'h1234, 3, 20, 12'h234, 1'b0};  // backpressure
      tbl[2] = '{16'h0000, 2, 0,  12'h001, 1'b1};  // zero seed, start while busy
      tbl[3] = '{16'hFFFF, 2, 3,  12'hFFF, 1'b1};

      clr = 1'b0; start = 1'b0; abort = 1'b0; resp_ready = 1'b0;
      num_chal = '0; seed = '0; puf_resp = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_puf_clr", puf_clr, 0);
      chk("rst_launch", puf_launch, 0);
      chk("rst_chal", puf_chal, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      clr = 1'b1;
      cyc();

      foreach (tbl[i]) run_batch(tbl[i].sd, tbl[i].n, tbl[i].stall, tbl[i].ef, tbl[i].noise);

      // num_chal = 0 leaves the block idle.
      seed = 16'h0055; num_chal = 8'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("zero_num_busy", busy, 0);
      dn = 0;
      repeat (5) begin
         if (done) dn++;
         cyc();
      end
      chk("zero_num_done", dn, 0);

      // Abort while in WAIT.
      seed = 16'h0005; num_chal = 8'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (8) cyc();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_valid", resp_valid, 0);
      chk("abort_puf_clr", puf_clr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 1);
      cyc();
      chk("abort_done_once", done, 0);

      // Abort in the same cycle as a handshake.
      seed = 16'h0007; num_chal = 8'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      k = 0;
      while (!resp_valid && k < LAT+4) begin
         cyc();
         k++;
      end
      chk("abort_hs_reach", resp_valid, 1);
      abort = 1'b1; resp_ready = 1'b1;
      cyc();
      abort = 1'b0; resp_ready = 1'b0;
      chk("abort_hs_done", done, 1);
      chk("abort_hs_busy", busy, 0);
      chk("abort_hs_valid", resp_valid, 0);
      chk("abort_hs_puf_clr", puf_clr, 0);
      cyc();
      chk("abort_hs_done_once", done, 0);
      chk("abort_hs_idle", busy, 0);
      run_batch(16'hBEEF, 1, 0, 12'hEEF, 1'b0);

      // Asynchronous reset during APPLY.
      seed = 16'h0009; num_chal = 8'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      chk("apply_puf_clr", puf_clr, 1);
      clr = 1'b0;
      #1;
      chk("mid_rst_puf_clr", puf_clr, 0);
      chk("mid_rst_chal", puf_chal, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", resp_valid, 0);
      chk("mid_rst_data", resp_data, 0);
      chk("mid_rst_rchal", resp_chal, 0);
      chk("mid_rst_done", done, 0);
      cyc();
      cyc();
      clr = 1'b1;
      cyc();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      run_batch(16'hACE1, 1, 0, 12'hCE1, 1'b0);

`ifdef FFAPUF_MAJ_VOTE_EN
      // Slice 0 votes 1,0,1,1,0 (majority 1) then 0,0,1,0,1 (majority 0).
      force_q.push_back(4'b1111); force_q.push_back(4'b0000); force_q.push_back(4'b1011);
      force_q.push_back(4'b0101); force_q.push_back(4'b1100);
      force_q.push_back(4'b0000); force_q.push_back(4'b1110); force_q.push_back(4'b0001);
      force_q.push_back(4'b1010); force_q.push_back(4'b0111);
      run_batch(16'hACE1, 2, 0, 12'hCE1, 1'b0);
`endif

      // Randomized batches.
      for (int r = 0; r < 6; r++) begin
         sd = LW'($urandom);
         n  = $urandom_range(1, 3);
         st = $urandom_range(0, 4);
         run_batch(sd, n, st, (sd == '0) ? CW'(1) : sd[CW-1:0], 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
